run_button_handshake_ctrl: RTL and testbench
============================================

Name: run_button_handshake_ctrl

Overview:
- Sequences the accumulator lab's "run" operation between the physical run button and the MicroBlaze GPIO inputs.
- Conditions the raw button: synchronise, debounce, polarity-correct.
- On each press, snapshots the switches and raises a level request to software. The request holds until software acknowledges through a GPIO output bit (four-phase handshake).
- Guarantees exactly one accumulate per press and counts presses lost while a request is outstanding.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive stable samples needed to accept a button level (10 ms at 100 MHz); minimum 2
BTN_ACTIVE_LOW, 1, 1 = raw button is pressed when low; 0 = pressed when high
SW_W, 16, switch/snapshot width

Ports:
clk  in  1  system clock, same 100 MHz clock as the MicroBlaze block
reset  in  1  asynchronous, active-high reset
btn_run  in  1  raw run button from pin
sw  in  SW_W  raw slide switches
proc_ack  in  1  acknowledge from MicroBlaze GPIO output bit; synchronous to clk
run_req  out  1  request to MicroBlaze GPIO input; level, held until acknowledged
sw_snap  out  SW_W  switch value captured at the accepted press
busy  out  1  high whenever FSM is not IDLE
overrun_cnt  out  8  presses accepted while a request was outstanding; saturating

Behaviour:
- Reset (async assert, sync deassert not required): run_req=0, sw_snap=0, busy=0, overrun_cnt=0, FSM=IDLE. Sync flops, debounced level and edge register all hold the released (0) level. Debounce counter=0.
- Reset asserted mid-operation drops run_req and busy immediately, with no wait for clk.
- Input conditioning:
  - btn_run passes through a 2-flop synchroniser.
  - It is then inverted if BTN_ACTIVE_LOW=1, giving btn_s (1 = pressed).
- Debouncer:
  - Counter increments while btn_s != btn_db; it clears whenever btn_s == btn_db.
  - When the counter reaches DEBOUNCE_CYCLES-1 and btn_s still differs, btn_db takes btn_s and the counter clears.
  - Net effect: btn_db follows a clean raw change exactly DEBOUNCE_CYCLES+2 clk edges later.
  - A glitch shorter than DEBOUNCE_CYCLES samples never changes btn_db.
- press = btn_db & ~btn_db_q, where btn_db_q is btn_db delayed one cycle. press is a one-cycle pulse.
- sw is not synchronised; it is captured only on the press cycle and treated as quasi-static.
- FSM states:
  - IDLE:
    - On press: sw_snap<=sw, run_req<=1, go REQ.
    - proc_ack is ignored in IDLE.
  - REQ:
    - run_req=1. proc_ack=1 -> run_req<=0, go ACKED.
    - Any press in REQ: overrun_cnt+1, saturating at 255. sw_snap is unchanged.
  - ACKED:
    - run_req=0. Go IDLE when proc_ack=0 and btn_db=0 in the same cycle.
    - A press in ACKED increments overrun_cnt. It can occur only after a release-and-repress that completes before ack drops.
- Latency:
  - press pulse -> run_req high at the next clk edge (1 cycle).
  - proc_ack high -> run_req low at the next edge.
- busy = (state != IDLE), registered alongside state.
- Simultaneous press and proc_ack in REQ: the ack transition is taken and the press counts as an overrun.
- Button held down indefinitely: only one request; re-arm requires btn_db=0.
- overrun_cnt clears only on reset.

Test Plan:
1. DEBOUNCE_CYCLES=4, BTN_ACTIVE_LOW=1, sw=16'h0005. Drive btn_run 1->0 and hold -> btn_db rises 6 edges later; run_req=1 and sw_snap=16'h0005 one edge after that; busy=1.
2. From scenario 1 state, pulse proc_ack=1 for 3 cycles -> run_req=0 one edge after ack rises, state ACKED. Release the button and drop ack -> IDLE after debounce; busy=0; overrun_cnt=0.
3. Bounce: raw button toggles low for 2 cycles, high for 1, low for 3, then high -> btn_db never rises, run_req stays 0.
4. With run_req=1 (no ack), change sw to 16'h00FF, then make 3 clean release/press cycles -> overrun_cnt=3, sw_snap still 16'h0005, run_req stays 1.
5. Apply 300 presses with no ack -> overrun_cnt saturates at 8'hFF and does not wrap.
6. Assert reset asynchronously between clk edges while run_req=1 -> run_req=0, sw_snap=0, overrun_cnt=0, busy=0 before the next edge. After release with the button still held, no request until release and re-press.

Source files
------------

// File: rtl/run_button_handshake_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : run_button_handshake_ctrl_if
// Description : Four-phase run request/acknowledge bundle to the MicroBlaze GPIO.
// Revision    : 1.0 - initial release
// ============================================================================
interface run_button_handshake_ctrl_if #(
  parameter int SW_W = 16
);
  logic            proc_ack;
  logic            run_req;
  logic [SW_W-1:0] sw_snap;
  logic            busy;
  logic [7:0]      overrun_cnt;

  modport master (
    input  proc_ack,
    output run_req,
    output sw_snap,
    output busy,
    output overrun_cnt
  );

  modport slave (
    output proc_ack,
    input  run_req,
    input  sw_snap,
    input  busy,
    input  overrun_cnt
  );
endinterface
`default_nettype wire

// File: rtl/run_button_handshake_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : run_button_handshake_ctrl
// Description : Debounced run button -> level request with switch snapshot.
// Revision    : 1.0 - initial release
// ============================================================================
module run_button_handshake_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int BTN_ACTIVE_LOW  = 1,
  parameter int SW_W            = 16
) (
  input  wire logic            clk,
  input  wire logic            reset,
  input  wire logic            btn_run,
  input  wire logic [SW_W-1:0] sw,
  run_button_handshake_ctrl_if.master hs
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic            RAW_IDLE = (BTN_ACTIVE_LOW != 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    ACKED = 2'd2
  } state_t;

  logic             sync1_q, sync2_q;
  logic             btn_s;
  logic [CNT_W-1:0] cnt_q;
  logic             db_q, db_dly_q;
  logic [1:0]       settle_q;
  logic             armed_q;
  logic             press;

  state_t           state_q, state_d;
  logic             run_req_q, busy_q;
  logic [SW_W-1:0]  snap_q, snap_d;
  logic [7:0]       ovr_q, ovr_d;

  assign btn_s = sync2_q ^ RAW_IDLE;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= RAW_IDLE;
      sync2_q <= RAW_IDLE;
    end else begin
      sync1_q <= btn_run;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      db_q     <= 1'b0;
      db_dly_q <= 1'b0;
    end else begin
      db_dly_q <= db_q;
      if (btn_s == db_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_MAX) begin
        db_q  <= btn_s;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // A button held through reset must be seen released once before it can
  // produce a press, otherwise the post-reset debounce would fire a request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      settle_q <= 2'b00;
      armed_q  <= 1'b0;
    end else begin
      settle_q <= {settle_q[0], 1'b1};
      armed_q  <= armed_q | (settle_q[1] & ~btn_s);
    end
  end

  assign press = db_q & ~db_dly_q & armed_q;

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    ovr_d   = ovr_q;
    case (state_q)
      IDLE: begin
        if (press) begin
          snap_d  = sw;
          state_d = REQ;
        end
      end
      REQ: begin
        if (hs.proc_ack) state_d = ACKED;
      end
      ACKED: begin
        if (!hs.proc_ack && !db_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (press && (state_q != IDLE) && (ovr_q != 8'hFF)) ovr_d = ovr_q + 8'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      run_req_q <= 1'b0;
      busy_q    <= 1'b0;
      snap_q    <= '0;
      ovr_q     <= '0;
    end else begin
      state_q   <= state_d;
      run_req_q <= (state_d == REQ);
      busy_q    <= (state_d != IDLE);
      snap_q    <= snap_d;
      ovr_q     <= ovr_d;
    end
  end

  assign hs.run_req     = run_req_q;
  assign hs.busy        = busy_q;
  assign hs.sw_snap     = snap_q;
  assign hs.overrun_cnt = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_run_button_handshake_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_run_button_handshake_ctrl
// Description : Randomised bench with a press/handshake event-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_run_button_handshake_ctrl;

  localparam int D    = 4;
  localparam int SW_W = 16;
  localparam int HOLD = D + 6;

  logic            clk     = 1'b0;
  logic            reset   = 1'b0;
  logic            btn_run = 1'b1;
  logic [SW_W-1:0] sw      = '0;

  run_button_handshake_ctrl_if #(.SW_W(SW_W)) bus ();

  run_button_handshake_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .BTN_ACTIVE_LOW (1),
    .SW_W           (SW_W)
  ) u_dut (
    .clk    (clk),
    .reset  (reset),
    .btn_run(btn_run),
    .sw     (sw),
    .hs     (bus.master)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  // Event-level model: 0 = idle, 1 = request outstanding, 2 = acknowledged
  int              m_state = 0;
  bit              m_db    = 1'b0;
  bit              m_ack   = 1'b0;
  logic [SW_W-1:0] m_snap  = '0;
  int              m_ovr   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_req"},  32'(bus.run_req),     32'(m_state == 1));
    chk({tag, "_busy"}, 32'(bus.busy),        32'(m_state != 0));
    chk({tag, "_snap"}, 32'(bus.sw_snap),     32'(m_snap));
    chk({tag, "_ovr"},  32'(bus.overrun_cnt), 32'(m_ovr));
  endtask

  task automatic m_press();
    if (m_state == 0) begin
      m_state = m_ack ? 2 : 1;
      m_snap  = sw;
    end else if (m_ovr < 255) begin
      m_ovr++;
    end
  endtask

  task automatic press_btn();
    @(negedge clk);
    btn_run = 1'b0;
    repeat (HOLD) @(negedge clk);
    if (!m_db) begin
      m_db = 1'b1;
      m_press();
    end
  endtask

  task automatic release_btn();
    @(negedge clk);
    btn_run = 1'b1;
    repeat (HOLD) @(negedge clk);
    if (m_db) begin
      m_db = 1'b0;
      if (m_state == 2 && !m_ack) m_state = 0;
    end
  endtask

  task automatic set_ack(input bit v);
    @(negedge clk);
    bus.proc_ack = v;
    repeat (3) @(negedge clk);
    m_ack = v;
    if (v && m_state == 1) m_state = 2;
    else if (!v && m_state == 2 && !m_db) m_state = 0;
  endtask

  task automatic glitch(input int n);
    logic lvl;
    @(negedge clk);
    lvl     = btn_run;
    btn_run = ~lvl;
    repeat (n) @(negedge clk);
    btn_run = lvl;
    repeat (HOLD) @(negedge clk);
  endtask

  task automatic set_btn_for(input logic v, input int n);
    btn_run = v;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    bus.proc_ack = 1'b0;
    #1 reset = 1'b1;
    #2;
    check_all("reset");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);

    // Scenario 1: exact press-to-request latency
    sw      = 16'h0005;
    btn_run = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("s1_req_before", 32'(bus.run_req), 32'd0);
    @(posedge clk);
    @(negedge clk);
    m_db = 1'b1;
    m_press();
    check_all("s1");
    chk("s1_snap5", 32'(bus.sw_snap), 32'h0005);
    repeat (4) @(negedge clk);

    // Scenario 2: ack drops run_req on the next edge
    bus.proc_ack = 1'b1;
    @(posedge clk);
    #1;
    chk("s2_ack_lat", 32'(bus.run_req), 32'd0);
    m_ack   = 1'b1;
    m_state = 2;
    repeat (3) @(negedge clk);
    check_all("s2_acked");
    set_ack(1'b0);
    check_all("s2_held");
    release_btn();
    check_all("s2_idle");

    // Scenario 3: bounce never qualifies
    @(negedge clk);
    set_btn_for(1'b0, 2);
    set_btn_for(1'b1, 1);
    set_btn_for(1'b0, 3);
    set_btn_for(1'b1, HOLD);
    check_all("s3_bounce");

    // Scenario 4: overruns while request is outstanding
    sw = 16'h0005;
    press_btn();
    sw = 16'h00FF;
    for (int i = 0; i < 3; i++) begin
      release_btn();
      press_btn();
    end
    check_all("s4");
    chk("s4_ovr3", 32'(bus.overrun_cnt), 32'd3);
    set_ack(1'b1);
    release_btn();
    set_ack(1'b0);
    check_all("s4_done");

    // Randomised actions
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 3))
        0: begin sw = SW_W'($urandom); press_btn(); end
        1: release_btn();
        2: set_ack(!m_ack);
        default: glitch(int'($urandom_range(1, D - 1)));
      endcase
      check_all("rnd");
    end

    // Scenario 5: saturation
    set_ack(1'b0);
    release_btn();
    press_btn();
    for (int i = 0; i < 300; i++) begin
      release_btn();
      press_btn();
    end
    check_all("s5");
    chk("s5_sat", 32'(bus.overrun_cnt), 32'hFF);

    // Scenario 6: asynchronous reset while requesting, button still held
    chk("s6_pre_req", 32'(bus.run_req), 32'd1);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    m_state = 0;
    m_snap  = '0;
    m_ovr   = 0;
    check_all("s6_async");
    @(negedge clk);
    reset = 1'b0;
    repeat (HOLD) @(negedge clk);
    check_all("s6_held");
    release_btn();
    check_all("s6_rel");
    sw = 16'h1234;
    press_btn();
    check_all("s6_repress");

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
